// File: rtl/sector_group_sequencer.sv
// Sector-group LED sequencer: holds the active group index, lights it solid while the
// system is DONE, and flashes the newly selected group after each advance strobe.
module sector_group_sequencer #(
    parameter int         NUM_GROUPS     = 4,
    parameter int         LEDS_PER_GROUP = 4,
    parameter int         BLINK_HALF     = 6250000,
    parameter int         FLASH_TOGGLES  = 6,
    parameter logic [1:0] DONE           = 2'b10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           main_state,
    input  logic                                 change_sector_group,
    output logic [$clog2(NUM_GROUPS)-1:0]        group_idx,
    output logic [NUM_GROUPS*LEDS_PER_GROUP-1:0] led,
    output logic                                 group_changed,
    output logic                                 flashing
);

    localparam int GW = $clog2(NUM_GROUPS);
    localparam int LW = NUM_GROUPS * LEDS_PER_GROUP;
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam int TW = $clog2(FLASH_TOGGLES) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_FLASH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] group_q, group_d;
    logic [LW-1:0] led_q, led_d;
    logic          changed_q, changed_d;
    logic          flashing_q, flashing_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [TW-1:0] tog_q, tog_d;
    logic [GW-1:0] next_group;
    logic          in_done;

    // One-hot-per-group LED pattern; constant slice bases keep the decode simple.
    function automatic logic [LW-1:0] group_mask(input logic [GW-1:0] g);
        logic [LW-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            if (g == GW'(i)) m[i*LEDS_PER_GROUP +: LEDS_PER_GROUP] = '1;
        end
        return m;
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        group_d    = group_q;
        led_d      = led_q;
        changed_d  = 1'b0;
        blink_d    = blink_q;
        tog_d      = tog_q;
        in_done    = (main_state == DONE);
        next_group = (group_q == GW'(NUM_GROUPS - 1)) ? '0 : group_q + GW'(1);

        case (state_q)
            S_IDLE: begin
                led_d   = '0;
                blink_d = '0;
                tog_d   = '0;
                if (in_done) begin
                    state_d = S_SHOW;
                    led_d   = group_mask(group_q);
                end
            end
            S_SHOW, S_FLASH: begin
                // Leaving DONE has priority over a coincident strobe.
                if (!in_done) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                    blink_d = '0;
                    tog_d   = '0;
                end else if (change_sector_group) begin
                    state_d   = S_FLASH;
                    group_d   = next_group;
                    changed_d = 1'b1;
                    led_d     = group_mask(next_group);
                    blink_d   = '0;
                    tog_d     = '0;
                end else if (state_q == S_SHOW) begin
                    led_d = group_mask(group_q);
                end else if (blink_q == BW'(BLINK_HALF - 1)) begin
                    blink_d = '0;
                    led_d   = led_q ^ group_mask(group_q);
                    tog_d   = tog_q + TW'(1);
                    if (tog_q == TW'(FLASH_TOGGLES - 1)) begin
                        state_d = S_SHOW;
                        led_d   = group_mask(group_q);
                        tog_d   = '0;
                    end
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = '0;
                blink_d = '0;
                tog_d   = '0;
            end
        endcase

        flashing_d = (state_d == S_FLASH);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            group_q    <= '0;
            led_q      <= '0;
            changed_q  <= 1'b0;
            flashing_q <= 1'b0;
            blink_q    <= '0;
            tog_q      <= '0;
        end else begin
            state_q    <= state_d;
            group_q    <= group_d;
            led_q      <= led_d;
            changed_q  <= changed_d;
            flashing_q <= flashing_d;
            blink_q    <= blink_d;
            tog_q      <= tog_d;
        end
    end

    assign group_idx     = group_q;
    assign led           = led_q;
    assign group_changed = changed_q;
    assign flashing      = flashing_q;

endmodule

// File: tb/tb_sector_group_sequencer.sv
// Scoreboard bench for sector_group_sequencer: stimulus queues timestamped expectations,
// a negedge monitor pops and compares them and every group_changed pulse.
module tb_sector_group_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] main_state;
    logic       change_sector_group;
    logic [1:0] group_idx;
    logic [5:0] led;
    logic       group_changed;
    logic       flashing;

    localparam logic [1:0] DONE = 2'b10;

    sector_group_sequencer #(
        .NUM_GROUPS    (3),
        .LEDS_PER_GROUP(2),
        .BLINK_HALF    (4),
        .FLASH_TOGGLES (2),
        .DONE          (DONE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .main_state         (main_state),
        .change_sector_group(change_sector_group),
        .group_idx          (group_idx),
        .led                (led),
        .group_changed      (group_changed),
        .flashing           (flashing)
    );

    typedef struct {
        int         cyc;
        logic [5:0] led;
        logic [1:0] gidx;
        logic       flash;
        string      tag;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] gidx;
    } pulse_t;

    exp_t   exp_q[$];
    pulse_t pulse_q[$];
    int     cyc    = 0;
    int     passed = 0;
    int     total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_at(input int d, input logic [5:0] l, input logic [1:0] g,
                             input logic f, input string tag);
        exp_t e;
        e.cyc   = cyc + d;
        e.led   = l;
        e.gidx  = g;
        e.flash = f;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic expect_pulse(input int d, input logic [1:0] g);
        pulse_t p;
        p.cyc  = cyc + d;
        p.gidx = g;
        pulse_q.push_back(p);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe();
        change_sector_group = 1'b1;
        tick(1);
        change_sector_group = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t   e;
        pulse_t p;
        if (group_changed === 1'b1) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_group_changed", 32'(group_changed), 32'd0);
            end else begin
                p = pulse_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(p.cyc));
                check("pulse_group_idx", 32'(group_idx), 32'(p.gidx));
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check({e.tag, "_led"}, 32'(led), 32'(e.led));
            check({e.tag, "_group_idx"}, 32'(group_idx), 32'(e.gidx));
            check({e.tag, "_flashing"}, 32'(flashing), 32'(e.flash));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:0] seq_g[3];
        logic [5:0] seq_m[3];
        seq_g = '{2'd2, 2'd0, 2'd1};
        seq_m = '{6'b110000, 6'b000011, 6'b001100};

        reset               = 1'b0;
        main_state          = 2'b00;
        change_sector_group = 1'b0;
        tick(3);
        reset = 1'b1;

        // Idle after reset, and a strobe in IDLE is ignored.
        expect_at(1, 6'b000000, 2'd0, 1'b0, "idle");
        tick(9);
        expect_at(3, 6'b000000, 2'd0, 1'b0, "idle_strobe_ignored");
        strobe();
        tick(10);

        // Enter DONE: group 0 solid.
        main_state = DONE;
        expect_at(1, 6'b000011, 2'd0, 1'b0, "show_g0");
        tick(5);

        // Strobe in SHOW: advance to group 1 and flash it.
        expect_pulse(1, 2'd1);
        expect_at(1, 6'b001100, 2'd1, 1'b1, "flash_start");
        expect_at(4, 6'b001100, 2'd1, 1'b1, "flash_hold_on");
        expect_at(5, 6'b000000, 2'd1, 1'b1, "flash_off");
        expect_at(8, 6'b000000, 2'd1, 1'b1, "flash_hold_off");
        expect_at(9, 6'b001100, 2'd1, 1'b0, "flash_done");
        strobe();
        tick(15);

        // Three spaced strobes, including wrap-around to group 0.
        for (int i = 0; i < 3; i++) begin
            expect_pulse(1, seq_g[i]);
            expect_at(1, seq_m[i], seq_g[i], 1'b1, "seq_flash");
            expect_at(9, seq_m[i], seq_g[i], 1'b0, "seq_solid");
            strobe();
            tick(19);
        end

        // Strobe coincident with leaving DONE: strobe dropped, group retained.
        change_sector_group = 1'b1;
        main_state          = 2'b00;
        expect_at(1, 6'b000000, 2'd1, 1'b0, "exit_drop_strobe");
        tick(1);
        change_sector_group = 1'b0;
        expect_at(5, 6'b000000, 2'd1, 1'b0, "idle_retain");
        tick(6);
        main_state = DONE;
        expect_at(1, 6'b001100, 2'd1, 1'b0, "relight_same");
        tick(3);

        // Strobe during FLASH restarts the sequence on the next group.
        expect_pulse(1, 2'd2);
        expect_at(1, 6'b110000, 2'd2, 1'b1, "restart_first");
        strobe();
        tick(2);
        expect_pulse(1, 2'd0);
        expect_at(1, 6'b000011, 2'd0, 1'b1, "restart_second");
        expect_at(4, 6'b000011, 2'd0, 1'b1, "restart_hold_on");
        expect_at(5, 6'b000000, 2'd0, 1'b1, "restart_off");
        expect_at(9, 6'b000011, 2'd0, 1'b0, "restart_done");
        strobe();
        tick(12);

        // Reset asserted mid-FLASH between clock edges.
        expect_pulse(1, 2'd1);
        expect_at(1, 6'b001100, 2'd1, 1'b1, "pre_reset_flash");
        strobe();
        tick(1);
        @(posedge clk);
        #2 reset = 1'b0;
        expect_at(0, 6'b000000, 2'd0, 1'b0, "async_reset");
        tick(2);
        reset = 1'b1;
        expect_at(1, 6'b000011, 2'd0, 1'b0, "after_reset");
        tick(4);

        check("expectations_drained", 32'(exp_q.size()), 32'd0);
        check("pulses_drained", 32'(pulse_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
